// File: rtl/rs_complex.sv
// Two-entry reservation station feeding the complex execute pipe.
// Each slot holds a 114-bit packed instruction plus its ROB tag. Operands that
// are not yet ready carry their producer tag in the low TAG_W bits of the
// operand field. Those operands capture results from the two broadcast buses,
// both when the instruction is dispatched and while it waits in its slot.

// One reservation slot: holds an entry and captures operands from the buses.
module rs_complex_slot #(
    parameter int TAG_W   = 4,
    parameter int ENTRY_W = 114
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_inst,
    input  logic [TAG_W-1:0]   wr_rob,
    input  logic               issue,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [31:0]        cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [31:0]        cdb1_data,
    output logic               valid,
    output logic [ENTRY_W-1:0] entry,
    output logic [TAG_W-1:0]   rob_num
);

    logic [ENTRY_W-1:0] payload;
    logic [ENTRY_W-1:0] src;
    logic [ENTRY_W-1:0] woke;

    // Returns {ready, value}. A ready operand is never replaced.
    // When both buses match the same tag, cdb0 takes priority.
    function automatic logic [32:0] grab(input logic rdy, input logic [31:0] val,
                                         input logic c0v, input logic [TAG_W-1:0] c0t,
                                         input logic [31:0] c0d, input logic c1v,
                                         input logic [TAG_W-1:0] c1t, input logic [31:0] c1d);
        logic [32:0] r;
        r = {rdy, val};
        if (!rdy) begin
            if (c0v && c0t == val[TAG_W-1:0])      r = {1'b1, c0d};
            else if (c1v && c1t == val[TAG_W-1:0]) r = {1'b1, c1d};
        end
        return r;
    endfunction

    // Operand capture applies to an incoming dispatch or to the resident entry.
    always_comb begin
        src  = wr_en ? wr_inst : payload;
        woke = src;
        {woke[5], woke[37:6]}   = grab(src[5], src[37:6], cdb0_valid, cdb0_tag, cdb0_data,
                                       cdb1_valid, cdb1_tag, cdb1_data);
        {woke[38], woke[70:39]} = grab(src[38], src[70:39], cdb0_valid, cdb0_tag, cdb0_data,
                                       cdb1_valid, cdb1_tag, cdb1_data);
    end

    // Slot state. The priority order is flush, then dispatch write, then issue, then wakeup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '0;
            rob_num <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid   <= 1'b1;
            payload <= woke;
            rob_num <= wr_rob;
        end else if (valid) begin
            if (issue) valid   <= 1'b0;
            else       payload <= woke;
        end
    end

    // A freed slot keeps its payload, but both operand-ready bits read 0.
    always_comb begin
        entry     = payload;
        entry[5]  = payload[5] & valid;
        entry[38] = payload[38] & valid;
    end

endmodule

// Top level: picks the dispatch slot, tracks the newer entry, fans out outputs.
module rs_complex #(
    parameter int TAG_W   = 4,
    parameter int ENTRY_W = 114
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               disp_valid,
    input  logic [ENTRY_W-1:0] disp_inst,
    input  logic [TAG_W-1:0]   disp_rob_num,
    output logic               disp_ready,
    input  logic               cdb0_valid,
    input  logic [TAG_W-1:0]   cdb0_tag,
    input  logic [31:0]        cdb0_data,
    input  logic               cdb1_valid,
    input  logic [TAG_W-1:0]   cdb1_tag,
    input  logic [31:0]        cdb1_data,
    input  logic               complex_0_issue,
    input  logic               complex_1_issue,
    output logic [ENTRY_W-1:0] rs_complex_0,
    output logic [ENTRY_W-1:0] rs_complex_1,
    output logic [TAG_W-1:0]   rs_complex_0_entry_num,
    output logic [TAG_W-1:0]   rs_complex_1_entry_num,
    output logic               selector
);

    localparam int SLOTS = 2;

    logic [SLOTS-1:0]              valid;
    logic [SLOTS-1:0]              issue;
    logic [SLOTS-1:0]              wr_en;
    logic [SLOTS-1:0][ENTRY_W-1:0] entry;
    logic [SLOTS-1:0][TAG_W-1:0]   rob_num;
    logic                          accept;
    logic                          tgt;

    // An issue in the same cycle does not free space for a dispatch.
    assign disp_ready = ~valid[0] | ~valid[1];
    assign accept     = disp_valid & disp_ready & ~flush;
    assign tgt        = valid[0];
    assign issue      = {complex_1_issue, complex_0_issue};
    assign wr_en      = {accept & tgt, accept & ~tgt};

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        rs_complex_slot #(.TAG_W(TAG_W), .ENTRY_W(ENTRY_W)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .wr_en      (wr_en[k]),
            .wr_inst    (disp_inst),
            .wr_rob     (disp_rob_num),
            .issue      (issue[k]),
            .cdb0_valid (cdb0_valid),
            .cdb0_tag   (cdb0_tag),
            .cdb0_data  (cdb0_data),
            .cdb1_valid (cdb1_valid),
            .cdb1_tag   (cdb1_tag),
            .cdb1_data  (cdb1_data),
            .valid      (valid[k]),
            .entry      (entry[k]),
            .rob_num    (rob_num[k])
        );
    end

    // The selector follows the last dispatch. A flush returns it to slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      selector <= 1'b0;
        else if (flush)  selector <= 1'b0;
        else if (accept) selector <= tgt;
    end

    assign rs_complex_0           = entry[0];
    assign rs_complex_1           = entry[1];
    assign rs_complex_0_entry_num = rob_num[0];
    assign rs_complex_1_entry_num = rob_num[1];

endmodule

// File: tb/tb_rs_complex.sv
// Bench for rs_complex. It runs a directed vector table taken from the
// reservation-station rules, then randomized traffic that is checked every
// cycle against a slot-array reference model. It also asserts reset in the
// middle of a cycle.
module tb_rs_complex;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         disp_valid = 1'b0;
    logic [113:0] disp_inst = '0;
    logic [3:0]   disp_rob_num = '0;
    logic         disp_ready;
    logic         cdb0_valid = 1'b0, cdb1_valid = 1'b0;
    logic [3:0]   cdb0_tag = '0, cdb1_tag = '0;
    logic [31:0]  cdb0_data = '0, cdb1_data = '0;
    logic         complex_0_issue = 1'b0, complex_1_issue = 1'b0;
    logic [113:0] rs_complex_0, rs_complex_1;
    logic [3:0]   rs_complex_0_entry_num, rs_complex_1_entry_num;
    logic         selector;

    int n_tests = 0;
    int n_fail  = 0;

    rs_complex dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid),
        .disp_inst(disp_inst), .disp_rob_num(disp_rob_num), .disp_ready(disp_ready),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .complex_0_issue(complex_0_issue), .complex_1_issue(complex_1_issue),
        .rs_complex_0(rs_complex_0), .rs_complex_1(rs_complex_1),
        .rs_complex_0_entry_num(rs_complex_0_entry_num),
        .rs_complex_1_entry_num(rs_complex_1_entry_num), .selector(selector)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic         m_v   [2];
    logic [113:0] m_p   [2];
    logic [3:0]   m_rob [2];
    logic         m_sel;

    function automatic logic [113:0] m_wake(input logic [113:0] p);
        for (int i = 0; i < 2; i++) begin
            int rb = (i == 0) ? 5 : 38;
            logic [31:0] f = p[rb+1 +: 32];
            if (!p[rb]) begin
                if (cdb0_valid && cdb0_tag == f[3:0]) begin
                    p[rb+1 +: 32] = cdb0_data; p[rb] = 1'b1;
                end else if (cdb1_valid && cdb1_tag == f[3:0]) begin
                    p[rb+1 +: 32] = cdb1_data; p[rb] = 1'b1;
                end
            end
        end
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin m_v[k] = 0; m_p[k] = '0; m_rob[k] = '0; end
        m_sel = 0;
    endtask

    task automatic model_step();
        logic iss [2];
        int   t;
        logic room;
        iss[0] = complex_0_issue; iss[1] = complex_1_issue;
        if (flush) begin
            m_v[0] = 0; m_v[1] = 0; m_sel = 0;
        end else begin
            room = !m_v[0] || !m_v[1];
            t    = m_v[0] ? 1 : 0;
            for (int k = 0; k < 2; k++)
                if (m_v[k]) begin
                    if (iss[k]) m_v[k] = 0;
                    else        m_p[k] = m_wake(m_p[k]);
                end
            if (disp_valid && room) begin
                m_p[t] = m_wake(disp_inst); m_v[t] = 1; m_rob[t] = disp_rob_num; m_sel = t[0];
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [113:0] e [2];
        logic [113:0] got [2];
        logic [3:0]   gn [2];
        got[0] = rs_complex_0; got[1] = rs_complex_1;
        gn[0]  = rs_complex_0_entry_num; gn[1] = rs_complex_1_entry_num;
        for (int k = 0; k < 2; k++) begin
            e[k] = m_p[k];
            if (!m_v[k]) begin e[k][5] = 1'b0; e[k][38] = 1'b0; end
            n_tests++;
            if (got[k] !== e[k] || gn[k] !== m_rob[k]) begin
                n_fail++;
                $display("FAIL %s slot%0d: got %h/%h want %h/%h", tag, k, got[k], gn[k], e[k], m_rob[k]);
            end
        end
        n_tests++;
        if (selector !== m_sel || disp_ready !== (!m_v[0] || !m_v[1])) begin
            n_fail++;
            $display("FAIL %s ctrl: got sel=%b dr=%b want sel=%b dr=%b", tag, selector, disp_ready,
                     m_sel, !m_v[0] || !m_v[1]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
    endtask

    function automatic logic [113:0] mk(input logic [31:0] op1, input logic r1,
                                        input logic [31:0] op2, input logic r2);
        return {32'hC0DE_0000, 6'h2A, 5'b10101, op2, r2, op1, r1, 5'h13};
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        flush, dv;
        logic [31:0] op1; logic r1; logic [31:0] op2; logic r2; logic [3:0] rob;
        logic c0v; logic [3:0] c0t; logic [31:0] c0d;
        logic c1v; logic [3:0] c1t; logic [31:0] c1d;
        logic i0, i1;
        logic [31:0] e_op1_0, e_op2_0; logic [1:0] e_rdy0; logic [3:0] e_num0;
        logic [31:0] e_op1_1, e_op2_1; logic [1:0] e_rdy1; logic [3:0] e_num1;
        logic e_sel, e_dr;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic do_reset();
        rst_n = 0; flush = 0; disp_valid = 0; disp_inst = '0; disp_rob_num = '0;
        cdb0_valid = 0; cdb1_valid = 0; cdb0_tag = '0; cdb1_tag = '0;
        cdb0_data = '0; cdb1_data = '0; complex_0_issue = 0; complex_1_issue = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic check_zero(input string tag);
        n_tests++;
        if (rs_complex_0 !== '0 || rs_complex_1 !== '0 || rs_complex_0_entry_num !== 4'd0 ||
            rs_complex_1_entry_num !== 4'd0 || selector !== 1'b0 || disp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got e0=%h e1=%h n0=%h n1=%h sel=%b dr=%b want all zero, dr=1", tag,
                     rs_complex_0, rs_complex_1, rs_complex_0_entry_num, rs_complex_1_entry_num,
                     selector, disp_ready);
        end
    endtask

    initial begin
        //            fl dv op1           r1 op2      r2 rob   c0v c0t c0d        c1v c1t c1d           i0 i1  | op1_0 op2_0 rdy0 n0 | op1_1 op2_1 rdy1 n1 | sel dr
        tbl[0]  = '{0,1,32'h5,        1, 32'h3,   1, 4'd2, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,0, 32'h5,  32'h3,   2'b11,4'd2, 32'h0,       32'h0,  2'b00,4'd0, 0,1};
        tbl[1]  = '{0,1,32'h7,        0, 32'h11,  1, 4'd4, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,0, 32'h5,  32'h3,   2'b11,4'd2, 32'h7,       32'h11, 2'b10,4'd4, 1,0};
        tbl[2]  = '{0,0,32'h0,        0, 32'h0,   0, 4'd0, 0,4'd0,32'h0,     1,4'd7,32'hDEAD_BEEF, 0,0, 32'h5,  32'h3,   2'b11,4'd2, 32'hDEAD_BEEF,32'h11,2'b11,4'd4, 1,0};
        tbl[3]  = '{0,1,32'hAA,       1, 32'hBB,  1, 4'd5, 0,4'd0,32'h0,     0,4'd0,32'h0,         1,0, 32'h5,  32'h3,   2'b00,4'd2, 32'hDEAD_BEEF,32'h11,2'b11,4'd4, 1,1};
        tbl[4]  = '{0,1,32'hAA,       1, 32'hBB,  1, 4'd5, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,0, 32'hAA, 32'hBB,  2'b11,4'd5, 32'hDEAD_BEEF,32'h11,2'b11,4'd4, 0,0};
        tbl[5]  = '{0,0,32'h0,        0, 32'h0,   0, 4'd0, 0,4'd0,32'h0,     0,4'd0,32'h0,         1,1, 32'hAA, 32'hBB,  2'b00,4'd5, 32'hDEAD_BEEF,32'h11,2'b00,4'd4, 0,1};
        tbl[6]  = '{0,1,32'h42,       1, 32'h3,   0, 4'd6, 1,4'd3,32'h1234,  0,4'd0,32'h0,         0,0, 32'h42, 32'h1234,2'b11,4'd6, 32'hDEAD_BEEF,32'h11,2'b00,4'd4, 0,1};
        tbl[7]  = '{0,1,32'h1,        1, 32'h2,   1, 4'd7, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,0, 32'h42, 32'h1234,2'b11,4'd6, 32'h1,       32'h2,  2'b11,4'd7, 1,0};
        tbl[8]  = '{1,1,32'h99,       1, 32'h98,  1, 4'd8, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,1, 32'h42, 32'h1234,2'b00,4'd6, 32'h1,       32'h2,  2'b00,4'd7, 0,1};
        tbl[9]  = '{0,1,32'h9,        0, 32'h5,   1, 4'd9, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,0, 32'h9,  32'h5,   2'b10,4'd9, 32'h1,       32'h2,  2'b00,4'd7, 0,1};
        tbl[10] = '{0,0,32'h0,        0, 32'h0,   0, 4'd0, 1,4'd9,32'hCAFE,  0,4'd0,32'h0,         1,0, 32'h9,  32'h5,   2'b00,4'd9, 32'h1,       32'h2,  2'b00,4'd7, 0,1};
        tbl[11] = '{0,1,32'h5,        0, 32'h6,   0, 4'd10,0,4'd0,32'h0,     0,4'd0,32'h0,         0,0, 32'h5,  32'h6,   2'b00,4'd10,32'h1,       32'h2,  2'b00,4'd7, 0,1};
        tbl[12] = '{0,0,32'h0,        0, 32'h0,   0, 4'd0, 1,4'd5,32'h100,   1,4'd5,32'h200,       0,0, 32'h100,32'h6,   2'b01,4'd10,32'h1,       32'h2,  2'b00,4'd7, 0,1};
        tbl[13] = '{0,0,32'h0,        0, 32'h0,   0, 4'd0, 1,4'd5,32'h555,   1,4'd6,32'h300,       0,0, 32'h100,32'h300, 2'b11,4'd10,32'h1,       32'h2,  2'b00,4'd7, 0,1};
        tbl[14] = '{0,0,32'h0,        0, 32'h0,   0, 4'd0, 0,4'd0,32'h0,     0,4'd0,32'h0,         0,1, 32'h100,32'h300, 2'b11,4'd10,32'h1,       32'h2,  2'b00,4'd7, 0,1};

        do_reset();
        #1 check_zero("reset");

        for (int i = 0; i < NV; i++) begin
            flush = tbl[i].flush; disp_valid = tbl[i].dv;
            disp_inst = mk(tbl[i].op1, tbl[i].r1, tbl[i].op2, tbl[i].r2);
            disp_rob_num = tbl[i].rob;
            cdb0_valid = tbl[i].c0v; cdb0_tag = tbl[i].c0t; cdb0_data = tbl[i].c0d;
            cdb1_valid = tbl[i].c1v; cdb1_tag = tbl[i].c1t; cdb1_data = tbl[i].c1d;
            complex_0_issue = tbl[i].i0; complex_1_issue = tbl[i].i1;
            tick();
            n_tests++;
            if (rs_complex_0[37:6] !== tbl[i].e_op1_0 || rs_complex_0[70:39] !== tbl[i].e_op2_0 ||
                {rs_complex_0[38], rs_complex_0[5]} !== tbl[i].e_rdy0 ||
                rs_complex_0_entry_num !== tbl[i].e_num0) begin
                n_fail++;
                $display("FAIL vec%0d slot0: got op1=%h op2=%h rdy=%b n=%0d want op1=%h op2=%h rdy=%b n=%0d",
                         i, rs_complex_0[37:6], rs_complex_0[70:39], {rs_complex_0[38], rs_complex_0[5]},
                         rs_complex_0_entry_num, tbl[i].e_op1_0, tbl[i].e_op2_0, tbl[i].e_rdy0, tbl[i].e_num0);
            end
            n_tests++;
            if (rs_complex_1[37:6] !== tbl[i].e_op1_1 || rs_complex_1[70:39] !== tbl[i].e_op2_1 ||
                {rs_complex_1[38], rs_complex_1[5]} !== tbl[i].e_rdy1 ||
                rs_complex_1_entry_num !== tbl[i].e_num1) begin
                n_fail++;
                $display("FAIL vec%0d slot1: got op1=%h op2=%h rdy=%b n=%0d want op1=%h op2=%h rdy=%b n=%0d",
                         i, rs_complex_1[37:6], rs_complex_1[70:39], {rs_complex_1[38], rs_complex_1[5]},
                         rs_complex_1_entry_num, tbl[i].e_op1_1, tbl[i].e_op2_1, tbl[i].e_rdy1, tbl[i].e_num1);
            end
            n_tests++;
            if (selector !== tbl[i].e_sel || disp_ready !== tbl[i].e_dr) begin
                n_fail++;
                $display("FAIL vec%0d ctrl: got sel=%b dr=%b want sel=%b dr=%b", i, selector, disp_ready,
                         tbl[i].e_sel, tbl[i].e_dr);
            end
            check_model($sformatf("vec%0d model", i));
        end

        // ---------------- randomized traffic ----------------
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] o1, o2;
            logic        r1, r2;
            logic [63:0] hi;
            r1 = 1'($urandom_range(0, 1)); r2 = 1'($urandom_range(0, 1));
            o1 = $urandom; o2 = $urandom;
            if (!r1) o1[3:0] = 4'($urandom_range(0, 3));
            if (!r2) o2[3:0] = 4'($urandom_range(0, 3));
            hi = {$urandom, $urandom};
            flush        = ($urandom_range(0, 15) == 0);
            disp_valid   = 1'($urandom_range(0, 1));
            disp_inst    = {hi[42:0], o2, r2, o1, r1, hi[47:43]};
            disp_rob_num = 4'($urandom);
            cdb0_valid   = 1'($urandom_range(0, 1)); cdb0_tag = 4'($urandom_range(0, 3)); cdb0_data = $urandom;
            cdb1_valid   = 1'($urandom_range(0, 1)); cdb1_tag = 4'($urandom_range(0, 3)); cdb1_data = $urandom;
            complex_0_issue = ($urandom_range(0, 3) == 0);
            complex_1_issue = ($urandom_range(0, 3) == 0);
            tick();
            check_model($sformatf("rand%0d", c));
        end

        // Reset in the middle of a cycle must clear the outputs at once.
        #3 rst_n = 0;
        #1 check_zero("async reset");
        model_reset();
        flush = 0; disp_valid = 0; cdb0_valid = 0; cdb1_valid = 0;
        complex_0_issue = 0; complex_1_issue = 0;
        @(negedge clk); rst_n = 1;
        for (int c = 0; c < 40; c++) begin
            disp_valid = 1'($urandom_range(0, 1));
            disp_inst  = {$urandom, $urandom, $urandom, $urandom};
            disp_rob_num = 4'($urandom);
            complex_0_issue = ($urandom_range(0, 2) == 0);
            complex_1_issue = ($urandom_range(0, 2) == 0);
            tick();
            check_model($sformatf("post%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
